// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator: default
// 640x480@60 segment lengths, counter width, scan phase type and a helper
// that sums the four segments of one axis.
package vga_timing_pkg;

  localparam int CNT_W     = 11;
  localparam int MAX_TOTAL = 2048;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;

  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    FRONT   = 2'd1,
    SYNC    = 2'd2,
    BACK    = 2'd3
  } phase_t;

  function automatic int seg_total(input int vis, input int fp, input int sp, input int bp);
    return vis + fp + sp + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter that wraps at the axis total, a phase
// FSM walking VISIBLE -> FRONT -> SYNC -> BACK, a registered sync output
// that lines up with the count, and a combinational wrap strobe that tells
// the next axis (or the frame logic) that this axis is rolling over.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   SEG_VIS  = H_VIS_DEF,
  parameter int   SEG_FP   = H_FP_DEF,
  parameter int   SEG_SP   = H_SYNC_DEF,
  parameter int   SEG_BP   = H_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = seg_total(SEG_VIS, SEG_FP, SEG_SP, SEG_BP);

  // Reject degenerate or oversized timings at elaboration
  if (SEG_VIS <= 0 || SEG_FP <= 0 || SEG_SP <= 0 || SEG_BP <= 0) begin : g_bad_segment
    $fatal(1, "vga_axis_counter: every segment length must be positive");
  end
  if (TOTAL > MAX_TOTAL) begin : g_bad_total
    $fatal(1, "vga_axis_counter: axis total exceeds counter range");
  end

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FRONT_CNT  = CNT_W'(SEG_VIS);
  localparam logic [CNT_W-1:0] SYNC_CNT   = CNT_W'(SEG_VIS + SEG_FP);
  localparam logic [CNT_W-1:0] BACK_CNT   = CNT_W'(SEG_VIS + SEG_FP + SEG_SP);
  localparam logic [CNT_W-1:0] ZERO_CNT   = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] next_cnt_s;
  logic             at_last_s;
  phase_t           phase_r;
  phase_t           phase_next_s;
  logic             sync_r;

  // Next position, wrapping to zero after the last count of the axis
  always_comb begin
    at_last_s = (cnt_r == LAST_CNT);
    if (at_last_s) begin
      next_cnt_s = ZERO_CNT;
    end else begin
      next_cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // Phase FSM keyed on the position the counter is about to take
  always_comb begin
    phase_next_s = phase_r;
    case (phase_r)
      VISIBLE: begin
        if (next_cnt_s == FRONT_CNT) phase_next_s = FRONT;
        else                         phase_next_s = VISIBLE;
      end
      FRONT: begin
        if (next_cnt_s == SYNC_CNT) phase_next_s = SYNC;
        else                        phase_next_s = FRONT;
      end
      SYNC: begin
        if (next_cnt_s == BACK_CNT) phase_next_s = BACK;
        else                        phase_next_s = SYNC;
      end
      BACK: begin
        if (next_cnt_s == ZERO_CNT) phase_next_s = VISIBLE;
        else                        phase_next_s = BACK;
      end
      default: phase_next_s = VISIBLE;
    endcase
  end

  // Counter, phase and sync all update together so sync has no lag vs count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= ZERO_CNT;
      phase_r <= VISIBLE;
      sync_r  <= ~SYNC_POL;
    end else if (step) begin
      cnt_r   <= next_cnt_s;
      phase_r <= phase_next_s;
      sync_r  <= (phase_next_s == SYNC) ? SYNC_POL : ~SYNC_POL;
    end else begin
      cnt_r   <= cnt_r;
      phase_r <= phase_r;
      sync_r  <= sync_r;
    end
  end

  assign cnt  = cnt_r;
  assign sync = sync_r;
  assign wrap = step & at_last_s;

endmodule

// File: rtl/vga_timing_counter.sv
// VGA raster timing generator: horizontal/vertical position, sync pulses and
// line/frame start strobes, advancing one pixel per clock while PIX_EN is high.
// Optional feature: define VGA_TIMING_FRAME_COUNT_EN to add a 16-bit frame
// counter output FRAME_CNT that increments with every FRAME_START.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int   HORIZONTAL_VISIBLE_AREA = H_VIS_DEF,
  parameter int   HORIZONTAL_FRONT_PORCH  = H_FP_DEF,
  parameter int   HORIZONTAL_SYNC_PULSE   = H_SYNC_DEF,
  parameter int   HORIZONTAL_BACK_PORCH   = H_BP_DEF,
  parameter int   VERTICAL_VISIBLE_AREA   = V_VIS_DEF,
  parameter int   VERTICAL_FRONT_PORCH    = V_FP_DEF,
  parameter int   VERTICAL_SYNC_PULSE     = V_SYNC_DEF,
  parameter int   VERTICAL_BACK_PORCH     = V_BP_DEF,
  parameter logic SYNC_POLARITY           = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PIX_EN,
  output logic [CNT_W-1:0] HCNT,
  output logic [CNT_W-1:0] VCNT,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             LINE_START,
`ifdef VGA_TIMING_FRAME_COUNT_EN
  output logic             FRAME_START,
  output logic [15:0]      FRAME_CNT
`else
  output logic             FRAME_START
`endif
);

  logic h_wrap_s;
  logic v_wrap_s;
  logic line_start_r;
  logic frame_start_r;

  vga_axis_counter #(
    .SEG_VIS  (HORIZONTAL_VISIBLE_AREA),
    .SEG_FP   (HORIZONTAL_FRONT_PORCH),
    .SEG_SP   (HORIZONTAL_SYNC_PULSE),
    .SEG_BP   (HORIZONTAL_BACK_PORCH),
    .SYNC_POL (SYNC_POLARITY)
  ) u_h_axis (
    .clk  (clk),
    .rst  (rst),
    .step (PIX_EN),
    .cnt  (HCNT),
    .sync (HSYNC),
    .wrap (h_wrap_s)
  );

  // The vertical axis only moves on the pixel that ends a line
  vga_axis_counter #(
    .SEG_VIS  (VERTICAL_VISIBLE_AREA),
    .SEG_FP   (VERTICAL_FRONT_PORCH),
    .SEG_SP   (VERTICAL_SYNC_PULSE),
    .SEG_BP   (VERTICAL_BACK_PORCH),
    .SYNC_POL (SYNC_POLARITY)
  ) u_v_axis (
    .clk  (clk),
    .rst  (rst),
    .step (h_wrap_s),
    .cnt  (VCNT),
    .sync (VSYNC),
    .wrap (v_wrap_s)
  );

  // Strobes are high only on the clock right after a wrap, cleared otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      line_start_r  <= h_wrap_s;
      frame_start_r <= v_wrap_s;
    end
  end

  assign LINE_START  = line_start_r;
  assign FRAME_START = frame_start_r;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_cnt_r;

  // Free-running frame count, rolls over naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_r <= 16'd0;
    end else if (v_wrap_s) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign FRAME_CNT = frame_cnt_r;
`endif

endmodule

// File: tb/tb_vga_timing_counter.sv
// Directed bench for vga_timing_counter. A default 640x480 instance covers
// line timing, hsync window and PIX_EN gating; a tiny 7x7 instance (sync and
// back porch of width 1) covers full frames, vsync and async reset mid-vsync.
module tb_vga_timing_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-timing instance
  logic        rst, pix_en;
  logic [10:0] hcnt, vcnt;
  logic        hsync, vsync, line_start, frame_start;
  // Small-timing instance
  logic        rst_sm, pen_sm;
  logic [10:0] hcnt_sm, vcnt_sm;
  logic        hsync_sm, vsync_sm, ls_sm, fs_sm;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] fcnt, fcnt_sm;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_h, exp_v, ls_seen;
  logic exp_ls, exp_fs, en;

  vga_timing_counter u_dut (
    .clk(clk), .rst(rst), .PIX_EN(pix_en),
    .HCNT(hcnt), .VCNT(vcnt), .HSYNC(hsync), .VSYNC(vsync),
    .LINE_START(line_start),
`ifdef VGA_TIMING_FRAME_COUNT_EN
    .FRAME_START(frame_start), .FRAME_CNT(fcnt)
`else
    .FRAME_START(frame_start)
`endif
  );

  vga_timing_counter #(
    .HORIZONTAL_VISIBLE_AREA(4), .HORIZONTAL_FRONT_PORCH(1),
    .HORIZONTAL_SYNC_PULSE(1),   .HORIZONTAL_BACK_PORCH(1),
    .VERTICAL_VISIBLE_AREA(3),   .VERTICAL_FRONT_PORCH(2),
    .VERTICAL_SYNC_PULSE(1),     .VERTICAL_BACK_PORCH(1),
    .SYNC_POLARITY(1'b0)
  ) u_small (
    .clk(clk), .rst(rst_sm), .PIX_EN(pen_sm),
    .HCNT(hcnt_sm), .VCNT(vcnt_sm), .HSYNC(hsync_sm), .VSYNC(vsync_sm),
    .LINE_START(ls_sm),
`ifdef VGA_TIMING_FRAME_COUNT_EN
    .FRAME_START(fs_sm), .FRAME_CNT(fcnt_sm)
`else
    .FRAME_START(fs_sm)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled clock of the 7x7 instance with its expected values
  task automatic step_small();
    tick();
    exp_fs = 1'b0;
    if (exp_h == 6) begin
      exp_h  = 0;
      exp_ls = 1'b1;
      if (exp_v == 6) begin
        exp_v  = 0;
        exp_fs = 1'b1;
      end else begin
        exp_v = exp_v + 1;
      end
    end else begin
      exp_h  = exp_h + 1;
      exp_ls = 1'b0;
    end
    check_val("sm_hcnt",  hcnt_sm,  exp_h);
    check_val("sm_vcnt",  vcnt_sm,  exp_v);
    check_val("sm_hsync", hsync_sm, (exp_h == 5) ? 0 : 1);
    check_val("sm_vsync", vsync_sm, (exp_v == 5) ? 0 : 1);
    check_val("sm_ls",    ls_sm,    exp_ls);
    check_val("sm_fs",    fs_sm,    exp_fs);
  endtask

  initial begin
    rst = 1'b1; pix_en = 1'b0; rst_sm = 1'b1; pen_sm = 1'b0;
    repeat (3) tick();

    // Reset state
    check_val("rst_hcnt",  hcnt, 0);
    check_val("rst_vcnt",  vcnt, 0);
    check_val("rst_hsync", hsync, 1);
    check_val("rst_vsync", vsync, 1);
    check_val("rst_ls",    line_start, 0);
    check_val("rst_fs",    frame_start, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check_val("rst_fcnt",  fcnt, 0);
`endif

    // First enabled clock after release
    rst = 1'b0; pix_en = 1'b1;
    tick();
    check_val("first_hcnt",  hcnt, 1);
    check_val("first_vcnt",  vcnt, 0);
    check_val("first_hsync", hsync, 1);
    check_val("first_ls",    line_start, 0);
    check_val("first_fs",    frame_start, 0);

    // Rest of line 0, hsync window 656..751
    for (int i = 2; i <= 799; i++) begin
      tick();
      check_val("run_hcnt",  hcnt, i);
      check_val("run_hsync", hsync, (i >= 656 && i <= 751) ? 0 : 1);
      check_val("run_ls",    line_start, 0);
    end
    check_val("eol_vcnt",  vcnt, 0);
    check_val("eol_vsync", vsync, 1);

    // Line wrap
    tick();
    check_val("wrap_hcnt", hcnt, 0);
    check_val("wrap_vcnt", vcnt, 1);
    check_val("wrap_ls",   line_start, 1);
    check_val("wrap_fs",   frame_start, 0);
    tick();
    check_val("post_hcnt", hcnt, 1);
    check_val("post_ls",   line_start, 0);

    // PIX_EN alternating: 800 enabled clocks over 1600
    exp_h = 1; exp_v = 1; ls_seen = 0;
    for (int i = 0; i < 1600; i++) begin
      en = (i % 2 == 0);
      pix_en = en;
      tick();
      exp_ls = 1'b0;
      if (en) begin
        if (exp_h == 799) begin
          exp_h = 0; exp_v = exp_v + 1; exp_ls = 1'b1;
        end else begin
          exp_h = exp_h + 1;
        end
      end
      check_val("tog_hcnt", hcnt, exp_h);
      check_val("tog_vcnt", vcnt, exp_v);
      check_val("tog_ls",   line_start, exp_ls);
      if (line_start) ls_seen++;
    end
    check_val("tog_ls_count", ls_seen, 1);
    check_val("tog_end_hcnt", hcnt, 1);
    check_val("tog_end_vcnt", vcnt, 2);

    // Move into hsync, then async reset between edges
    pix_en = 1'b1;
    repeat (699) tick();
    check_val("pre_rst_hcnt",  hcnt, 700);
    check_val("pre_rst_hsync", hsync, 0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_hcnt",  hcnt, 0);
    check_val("arst_vcnt",  vcnt, 0);
    check_val("arst_hsync", hsync, 1);
    pix_en = 1'b0;

    // Small instance: one full 7x7 frame
    tick();
    rst_sm = 1'b0; pen_sm = 1'b1;
    exp_h = 0; exp_v = 0;
    for (int i = 0; i < 49; i++) step_small();
    check_val("frame_hcnt", hcnt_sm, 0);
    check_val("frame_vcnt", vcnt_sm, 0);
    check_val("frame_fs",   fs_sm, 1);
    check_val("frame_ls",   ls_sm, 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check_val("frame_cnt",  fcnt_sm, 1);
`endif

    // Into vsync (line 5, pixel 3), then async reset between edges
    for (int i = 0; i < 38; i++) step_small();
    check_val("mid_vcnt",  vcnt_sm, 5);
    check_val("mid_vsync", vsync_sm, 0);
    #2 rst_sm = 1'b1;
    #1;
    check_val("sm_arst_hcnt",  hcnt_sm, 0);
    check_val("sm_arst_vcnt",  vcnt_sm, 0);
    check_val("sm_arst_hsync", hsync_sm, 1);
    check_val("sm_arst_vsync", vsync_sm, 1);
    check_val("sm_arst_ls",    ls_sm, 0);
    check_val("sm_arst_fs",    fs_sm, 0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check_val("sm_arst_fcnt",  fcnt_sm, 0);
`endif

    // Counting restarts from 0,0
    rst_sm = 1'b0;
    tick();
    check_val("restart_hcnt", hcnt_sm, 1);
    check_val("restart_vcnt", vcnt_sm, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_counter.md
Name: vga_timing_counter

Overview:
- Generates the raster scan position (HCNT, VCNT) and the HSYNC/VSYNC pulses for a VGA output.
- Sits directly upstream of the display-area signal generator, which consumes HCNT/VCNT.
- Also feeds line/frame strobes to the pixel source.
- Advances one pixel per clock when PIX_EN is high, so the system clock can be faster than the pixel clock.

Parameters:
- HORIZONTAL_VISIBLE_AREA, 640, visible pixels per line
- HORIZONTAL_FRONT_PORCH, 16, pixels between visible area and hsync
- HORIZONTAL_SYNC_PULSE, 96, hsync width in pixels
- HORIZONTAL_BACK_PORCH, 48, pixels after hsync
- VERTICAL_VISIBLE_AREA, 480, visible lines per frame
- VERTICAL_FRONT_PORCH, 10, lines between visible area and vsync
- VERTICAL_SYNC_PULSE, 2, vsync width in lines
- VERTICAL_BACK_PORCH, 33, lines after vsync
- SYNC_POLARITY, 0, active level of HSYNC/VSYNC (0 = active-low)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- PIX_EN  input  1  pixel-advance enable; counters step only when high
- HCNT  output  11  horizontal position, 0..H_TOTAL-1
- VCNT  output  11  vertical position, 0..V_TOTAL-1
- HSYNC  output  1  horizontal sync, level per SYNC_POLARITY
- VSYNC  output  1  vertical sync, level per SYNC_POLARITY
- LINE_START  output  1  one-clock strobe when HCNT becomes 0
- FRAME_START  output  1  one-clock strobe when HCNT and VCNT both become 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: HCNT=0, VCNT=0, HSYNC=VSYNC=~SYNC_POLARITY, LINE_START=0, FRAME_START=0.
- First enabled clock after reset release moves HCNT to 1. No strobe is issued for the reset-held position 0,0.
- Totals:
  - H_TOTAL = sum of the four horizontal parameters (default 800).
  - V_TOTAL = sum of the four vertical parameters (default 525).
  - Both must be ≤ 2048. Elaboration fails otherwise, and also if any parameter is ≤ 0.
- Counting, on each clk edge with PIX_EN=1:
  - HCNT increments.
  - If HCNT==H_TOTAL-1, HCNT wraps to 0 and VCNT increments.
  - If additionally VCNT==V_TOTAL-1, VCNT wraps to 0.
  - With PIX_EN=0, all outputs hold, and strobes are 0.
- Horizontal phase FSM (registered, advanced with HCNT): VISIBLE → FRONT → SYNC → BACK → VISIBLE.
  - Transitions occur when the next HCNT equals HORIZONTAL_VISIBLE_AREA, +FRONT, +SYNC, and 0 respectively.
  - The vertical FSM is identical, keyed on next VCNT, and steps only on horizontal wrap.
- HSYNC is active exactly while HCNT ∈ [HV+HFP, HV+HFP+HSP-1].
  - It is registered from the next-count value, so it has zero latency relative to HCNT (same edge).
- VSYNC is active exactly while VCNT ∈ [VV+VFP, VV+VFP+VSP-1]. It changes on the same edge as VCNT.
- LINE_START=1 for the single clock on which HCNT has just become 0 through a wrap. It is 0 on the following clocks even if PIX_EN stays 0.
- FRAME_START=1 for the single clock on which both counters have just wrapped to 0. LINE_START is also 1 on that clock.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). Counting restarts from 0,0.
- Boundary cases:
  - A sync pulse of width 1 must still produce exactly one active count.
  - A back porch of 1 must still wrap correctly.

Optional Feature:
- Macro: VGA_TIMING_FRAME_COUNT_EN.
- When defined:
  - Adds output FRAME_CNT [15:0].
  - Reset value 0.
  - Increments on every clock that asserts FRAME_START; wraps 0xFFFF→0.
- When undefined: the port and register are absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 constants;
  - the CNT_W=11 width constant;
  - the phase enum type {VISIBLE, FRONT, SYNC, BACK};
  - a function computing a total from four segment lengths.
- Sub-module vga_axis_counter:
  - one generic axis with counter, phase FSM, sync and wrap output;
  - instantiated twice: horizontal (step=PIX_EN) and vertical (step=horizontal wrap).

Test Plan:
- Reset held, then released with PIX_EN=1 → after 1 clock HCNT=1, VCNT=0, HSYNC=1, no strobes.
- Run 799 enabled clocks from reset → HCNT=799. Next clock → HCNT=0, VCNT=1, LINE_START=1 for one clock.
- Horizontal sync window → HSYNC=0 exactly for HCNT 656..751 and 1 at HCNT 655 and 752. VSYNC=0 exactly for VCNT 490..491.
- Full frame of 420000 enabled clocks → HCNT=0, VCNT=0, FRAME_START=1 and LINE_START=1 on the same clock. With VGA_TIMING_FRAME_COUNT_EN, FRAME_CNT=1.
- PIX_EN toggled 1/0 each clock for 1600 clocks → HCNT advances 800 (wraps once). Outputs are stable in disabled clocks. LINE_START lasts one clock.
- Assert rst asynchronously at HCNT=700, VCNT=490 (mid-vsync) → HCNT=VCNT=0 and HSYNC=VSYNC=1 before the next clk edge.
